// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state type and sizing helper for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    REL_DB
  } state_e;

  function automatic int db_cnt_w(input int debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction

endpackage

// File: rtl/keypad_event_slot.sv
// rtl/keypad_event_slot.sv - one-entry valid/ready event holding register with sticky overrun
module keypad_event_slot
  import keypad_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         post,
  input  logic [W-1:0] post_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         overrun
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         overrun_q, overrun_d;
  logic         xfer;

  // A post in the same cycle as a transfer refills the slot instead of overrunning.
  always_comb begin
    xfer      = valid_q && ready;
    valid_d   = valid_q && !ready;
    data_d    = data_q;
    overrun_d = overrun_q;
    if (post) begin
      if (!valid_q || xfer) begin
        valid_d = 1'b1;
        data_d  = post_data;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid   = valid_q;
  assign data    = data_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - matrix keypad scanner with debounce and event handshake (option: KEYPAD_AUTOREPEAT_EN)
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int NUM_ROWS        = 4,
  parameter int NUM_COLS        = 4,
  parameter int DWELL_CYCLES    = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 10_000_000,
  parameter int REPEAT_PERIOD   = 2_000_000,
  parameter int KEY_W           = $clog2(NUM_ROWS * NUM_COLS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_COLS-1:0] cols,
  output logic [NUM_ROWS-1:0] rows,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                overrun
);

  localparam int RW  = $clog2(NUM_ROWS);
  localparam int CW  = $clog2(NUM_COLS);
  localparam int DWW = $clog2(DWELL_CYCLES + 1);
  localparam int DBW = db_cnt_w(DEBOUNCE_CYCLES);

  logic [NUM_COLS-1:0] cols_meta_q, cs_q;
  state_e              state_q, state_d;
  logic [RW-1:0]       row_q, row_d, next_row;
  logic [CW-1:0]       col_q, col_d, low_col;
  logic [DWW-1:0]      dwell_q, dwell_d;
  logic [DBW-1:0]      db_q, db_d;
  logic                post, post_any;
  logic [KEY_W-1:0]    post_code;

  assign next_row  = (row_q == RW'(NUM_ROWS - 1)) ? '0 : row_q + RW'(1);
  assign post_code = KEY_W'(row_q) * KEY_W'(NUM_COLS) + KEY_W'(col_q);

  always_comb begin
    rows        = '0;
    rows[row_q] = 1'b1;
  end

  // Descending scan so the lowest set column is the last one written.
  always_comb begin
    low_col = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (cs_q[i]) low_col = CW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    dwell_d = dwell_q;
    db_d    = db_q;
    post    = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (dwell_q == DWW'(DWELL_CYCLES - 1)) begin
          dwell_d = '0;
          if (cs_q != '0) begin
            col_d   = low_col;
            db_d    = '0;
            state_d = PRESS_DB;
          end else begin
            row_d = next_row;
          end
        end else begin
          dwell_d = dwell_q + DWW'(1);
        end
      end
      PRESS_DB: begin
        if (!cs_q[col_q]) begin
          state_d = SCAN;
          row_d   = next_row;
        end else if (db_q == DBW'(DEBOUNCE_CYCLES)) begin
          post    = 1'b1;
          state_d = HELD;
        end else begin
          db_d = db_q + DBW'(1);
        end
      end
      HELD: begin
        if (!cs_q[col_q]) begin
          db_d    = '0;
          state_d = REL_DB;
        end
      end
      REL_DB: begin
        if (cs_q[col_q]) begin
          db_d    = '0;
          state_d = HELD;
        end else if (db_q == DBW'(DEBOUNCE_CYCLES)) begin
          state_d = SCAN;
          row_d   = next_row;
        end else begin
          db_d = db_q + DBW'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cols_meta_q <= '0;
      cs_q        <= '0;
      state_q     <= SCAN;
      row_q       <= '0;
      col_q       <= '0;
      dwell_q     <= '0;
      db_q        <= '0;
    end else begin
      cols_meta_q <= cols;
      cs_q        <= cols_meta_q;
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      dwell_q     <= dwell_d;
      db_q        <= db_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPW = $clog2(((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1);

  logic [RPW-1:0] rpt_q, rpt_d, rpt_last;
  logic           first_q, first_d, rpt_post;

  // Counter freezes in REL_DB so a bounce back to HELD keeps the repeat cadence.
  always_comb begin
    rpt_d    = rpt_q;
    first_d  = first_q;
    rpt_post = 1'b0;
    rpt_last = first_q ? RPW'(REPEAT_DELAY - 1) : RPW'(REPEAT_PERIOD - 1);
    if (state_q == SCAN || state_q == PRESS_DB) begin
      rpt_d   = '0;
      first_d = 1'b1;
    end else if (state_q == HELD && cs_q[col_q]) begin
      if (rpt_q == rpt_last) begin
        rpt_post = 1'b1;
        rpt_d    = '0;
        first_d  = 1'b0;
      end else begin
        rpt_d = rpt_q + RPW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rpt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      rpt_q   <= rpt_d;
      first_q <= first_d;
    end
  end

  assign post_any = post | rpt_post;
`else
  assign post_any = post;
`endif

  keypad_event_slot #(
    .W(KEY_W)
  ) u_slot (
    .clk      (clk),
    .resetn   (reset),
    .post     (post_any),
    .post_data(post_code),
    .ready    (key_ready),
    .valid    (key_valid),
    .data     (key_code),
    .overrun  (overrun)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int KW = 4;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int HOLD_EVENTS = 4;
`else
  localparam int HOLD_EVENTS = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] cols;
  logic [NR-1:0] rows;
  logic [KW-1:0] key_code;
  logic          key_valid;
  logic          key_ready;
  logic          overrun;
  logic [15:0]   pressed;

  int tests  = 0;
  int fails  = 0;
  int edge_n = 0;
  int e0     = 0;
  int ev_cnt = 0;
  int ev0    = 0;
  logic [KW-1:0] last_code = '0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .NUM_ROWS       (NR),
    .NUM_COLS       (NC),
    .DWELL_CYCLES   (4),
    .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cols     (cols),
    .rows     (rows),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .overrun  (overrun)
  );

  // Passive switch matrix: a closed key connects its row drive to its column.
  always_comb begin
    cols = '0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (rows[r] && pressed[r*NC + c]) cols[c] = 1'b1;
  end

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (key_valid && key_ready) begin
      ev_cnt    <= ev_cnt + 1;
      last_code <= key_code;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the falling edge that follows rising edge k after the last reset release.
  task automatic goto(input int k);
    while (edge_n < e0 + k + 1) @(negedge clk);
  endtask

  initial begin
    reset     = 1'b0;
    key_ready = 1'b1;
    pressed   = '0;
    repeat (3) @(negedge clk);
    check("rst_rows", rows, 32'h1);
    check("rst_valid", key_valid, 32'h0);
    check("rst_code", key_code, 32'h0);
    check("rst_overrun", overrun, 32'h0);
    reset = 1'b1;
    e0    = edge_n;

    goto(3);  check("scan_row1", rows, 32'h2);
    goto(14); check("scan_row3", rows, 32'h8);
    goto(15); check("scan_wrap", rows, 32'h1);

    pressed[9] = 1'b1;
    ev0 = ev_cnt;
    goto(35); check("press_early", key_valid, 32'h0);
    check("press_frozen", rows, 32'h4);
    goto(36); check("press_valid", key_valid, 32'h1);
    check("press_code", key_code, 32'h9);
    goto(37); check("press_drop", key_valid, 32'h0);
    goto(40); pressed[9] = 1'b0;
    goto(51); check("rel_frozen", rows, 32'h4);
    goto(52); check("rel_advance", rows, 32'h8);
    check("press_once", ev_cnt - ev0, 32'h1);

    ev0 = ev_cnt;
    pressed[6] = 1'b1;
    goto(66); pressed[6] = 1'b0;
    goto(67); pressed[6] = 1'b1;
    goto(68); check("bounce_frozen", rows, 32'h2);
    goto(69); check("bounce_abort", rows, 32'h4);
    goto(93); check("bounce_early", key_valid, 32'h0);
    goto(94); check("bounce_valid", key_valid, 32'h1);
    check("bounce_code", key_code, 32'h6);
    goto(96); pressed[6] = 1'b0;
    goto(108); check("bounce_once", ev_cnt - ev0, 32'h1);

    key_ready  = 1'b0;
    pressed[3] = 1'b1;
    goto(129); check("ovr_first_valid", key_valid, 32'h1);
    check("ovr_first_code", key_code, 32'h3);
    check("ovr_clear", overrun, 32'h0);
    goto(130); pressed[3] = 1'b0; pressed[5] = 1'b1;
    goto(154); check("ovr_not_yet", overrun, 32'h0);
    goto(155); check("ovr_set", overrun, 32'h1);
    check("ovr_code_kept", key_code, 32'h3);
    check("ovr_valid_kept", key_valid, 32'h1);
    goto(156); key_ready = 1'b1;
    goto(157); check("ovr_drain", key_valid, 32'h0);
    check("ovr_taken_code", last_code, 32'h3);
    pressed[5] = 1'b0;

    goto(170);
    ev0 = ev_cnt;
    pressed[0] = 1'b1; pressed[2] = 1'b1;
    goto(190); check("multi_valid", key_valid, 32'h1);
    check("multi_code", key_code, 32'h0);
    goto(192); pressed[0] = 1'b0; pressed[2] = 1'b0;
    goto(206); check("multi_once", ev_cnt - ev0, 32'h1);

    pressed[8] = 1'b1;
    goto(215); reset = 1'b0;
    goto(216); check("mid_rst_rows", rows, 32'h1);
    check("mid_rst_valid", key_valid, 32'h0);
    check("mid_rst_overrun", overrun, 32'h0);
    check("mid_rst_code", key_code, 32'h0);
    pressed[8] = 1'b0;
    goto(218);
    reset      = 1'b1;
    e0         = edge_n;
    ev0        = ev_cnt;
    pressed[1] = 1'b1;
    goto(11); check("hold_early", key_valid, 32'h0);
    goto(12); check("hold_valid", key_valid, 32'h1);
    check("hold_code", key_code, 32'h1);
    goto(57); pressed[1] = 1'b0;
    goto(68); check("hold_frozen", rows, 32'h1);
    goto(69); check("hold_advance", rows, 32'h2);
    goto(70); check("hold_events", ev_cnt - ev0, HOLD_EVENTS);
    check("hold_last_code", last_code, 32'h1);
    check("hold_no_overrun", overrun, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
